ioblock_bank: RTL and testbench

Parametrised bank of WIDTH programmable FPGA I/O cells sharing one clock, a serial configuration chain and a double-buffered active configuration. Each cell offers tristate control, an optional output/tristate register, and a direct or registered input path. The bank sits at the device periphery between the routing fabric (OUT, TS, IN) and the package pins (PIN), and is programmed by the configuration controller through the CFG* chain.

---
 rtl/ioblock_pkg.sv | 31 +++
 rtl/ioblock_bank_if.sv | 25 ++
 rtl/ioblock_cell.sv | 62 ++++++
 rtl/ioblock_bank.sv | 45 ++++
 tb/tb_ioblock_bank.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/ioblock_pkg.sv
// ioblock_pkg: shared constants and helpers for the I/O cell bank.
// Cell field layout is {OREG, DORREG, TSMUX[1:0]}.
package ioblock_pkg;

  localparam int CFGW       = 4;
  localparam int TSMUX_LSB  = 0;
  localparam int DORREG_BIT = 2;
  localparam int OREG_BIT   = 3;

  typedef enum logic [1:0] {
    TSMUX_Z   = 2'b00,
    TSMUX_TS  = 2'b01,
    TSMUX_DRV = 2'b10
  } tsmux_e;

  // 2'b11 drives like TSMUX_DRV, so only bit 1 is decoded for that case
  function automatic logic cell_oe(
    input logic [1:0] mux,
    input logic       ts
  );
    logic oe;
    oe = 1'b0;
    unique case (1'b1)
      mux[1]:            oe = 1'b1;
      (mux == TSMUX_TS): oe = ts;
      default:           oe = 1'b0;
    endcase
    return oe;
  endfunction

endpackage

// File: rtl/ioblock_bank_if.sv
// ioblock_bank_if: fabric data and configuration chain bundle.
// master = fabric/config controller, slave = I/O bank.
interface ioblock_bank_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] OUT;
  logic [WIDTH-1:0] TS;
  logic [WIDTH-1:0] IN;
  logic             CFGEN;
  logic             CFGIN;
  logic             CFGLD;
  logic             CFGOUT;

  modport master (
    output OUT, TS, CFGEN, CFGIN, CFGLD,
    input  IN, CFGOUT
  );

  modport slave (
    input  OUT, TS, CFGEN, CFGIN, CFGLD,
    output IN, CFGOUT
  );

endinterface

// File: rtl/ioblock_cell.sv
// ioblock_cell: one programmable I/O pin with tristate and registers.
// IOBLOCK_BANK_SYNC2_EN selects a two-flop input synchroniser.
module ioblock_cell
  import ioblock_pkg::*;
(
  input  logic            IOCLK,
  input  logic            IORSTN,
  inout  wire             PIN,
  input  logic            OUT,
  input  logic            TS,
  output logic            IN,
  input  logic [CFGW-1:0] CFG
);

  logic out_q;
  logic ts_q;
  logic in_q;
  logic out_eff;
  logic ts_eff;
  logic oe;

  // Output flops run in every mode so an OREG switch has no bubble
  always_ff @(posedge IOCLK or negedge IORSTN) begin
    if (!IORSTN) begin
      out_q <= 1'b0;
      ts_q  <= 1'b0;
    end else begin
      out_q <= OUT;
      ts_q  <= TS;
    end
  end

  assign out_eff = CFG[OREG_BIT] ? out_q : OUT;
  assign ts_eff  = CFG[OREG_BIT] ? ts_q  : TS;
  assign oe      = cell_oe(CFG[TSMUX_LSB +: 2], ts_eff);
  assign PIN     = oe ? out_eff : 1'bz;

`ifdef IOBLOCK_BANK_SYNC2_EN
  logic in_s1;

  always_ff @(posedge IOCLK or negedge IORSTN) begin
    if (!IORSTN) begin
      in_s1 <= 1'b0;
      in_q  <= 1'b0;
    end else begin
      in_s1 <= PIN;
      in_q  <= in_s1;
    end
  end
`else
  always_ff @(posedge IOCLK or negedge IORSTN) begin
    if (!IORSTN) begin
      in_q <= 1'b0;
    end else begin
      in_q <= PIN;
    end
  end
`endif

  assign IN = CFG[DORREG_BIT] ? in_q : PIN;

endmodule

// File: rtl/ioblock_bank.sv
// ioblock_bank: WIDTH I/O cells behind a serial config chain.
// Build option IOBLOCK_BANK_SYNC2_EN: two-flop input path per cell.
module ioblock_bank
  import ioblock_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             IOCLK,
  input  logic             IORSTN,
  inout  wire  [WIDTH-1:0] PIN,
  ioblock_bank_if.slave    bus
);

  localparam int N = CFGW * WIDTH;

  logic [N-1:0] chain_q;
  logic [N-1:0] cfg_q;

  // Shift wins over load; the active copy only moves on a clean load
  always_ff @(posedge IOCLK or negedge IORSTN) begin
    if (!IORSTN) begin
      chain_q <= '0;
      cfg_q   <= '0;
    end else if (bus.CFGEN) begin
      chain_q <= {chain_q[N-2:0], bus.CFGIN};
    end else if (bus.CFGLD) begin
      cfg_q   <= chain_q;
    end
  end

  assign bus.CFGOUT = chain_q[N-1];

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    ioblock_cell u_cell (
      .IOCLK  (IOCLK),
      .IORSTN (IORSTN),
      .PIN    (PIN[i]),
      .OUT    (bus.OUT[i]),
      .TS     (bus.TS[i]),
      .IN     (bus.IN[i]),
      .CFG    (cfg_q[CFGW*i +: CFGW])
    );
  end

endmodule

// File: tb/tb_ioblock_bank.sv
// tb_ioblock_bank: directed checks of pin drive, registers and chain.
// External pin drivers pull undriven pins to a known level.
module tb_ioblock_bank;

  localparam int W = 8;

  logic IOCLK = 1'b0;
  logic IORSTN;
  wire  [W-1:0] PIN;
  logic [W-1:0] ext_en;
  logic [W-1:0] ext_val;
  logic [31:0]  pat;
  logic         expb;
  int vectors = 0;
  int miscompares = 0;

  always #5 IOCLK = ~IOCLK;

  for (genvar i = 0; i < W; i++) begin : g_ext
    assign PIN[i] = ext_en[i] ? ext_val[i] : 1'bz;
  end

  ioblock_bank_if #(.WIDTH(W)) bus ();

  ioblock_bank #(.WIDTH(W)) dut (
    .IOCLK  (IOCLK),
    .IORSTN (IORSTN),
    .PIN    (PIN),
    .bus    (bus.slave)
  );

  task automatic tick();
    @(posedge IOCLK);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic shift_word(input logic [31:0] w);
    bus.CFGEN = 1'b1;
    for (int i = 31; i >= 0; i--) begin
      bus.CFGIN = w[i];
      tick();
    end
    bus.CFGEN = 1'b0;
    bus.CFGIN = 1'b0;
  endtask

  task automatic load();
    bus.CFGLD = 1'b1;
    tick();
    bus.CFGLD = 1'b0;
  endtask

  initial begin
    IORSTN    = 1'b1;
    bus.OUT   = '0;
    bus.TS    = '0;
    bus.CFGEN = 1'b0;
    bus.CFGIN = 1'b0;
    bus.CFGLD = 1'b0;
    ext_en    = 8'hFF;
    ext_val   = 8'hFF;
    #2 IORSTN = 1'b0;
    #10;
    // reset: pins float, external level passes through
    chk("rst_pin_hi", 32'(PIN), 32'h0000_00FF);
    chk("rst_in_hi", 32'(bus.IN), 32'h0000_00FF);
    chk("rst_cfgout", 32'(bus.CFGOUT), 32'h0);
    ext_val = 8'h00;
    bus.OUT = 8'hFF;
    #2;
    chk("rst_pin_lo", 32'(PIN), 32'h0);
    chk("rst_in_lo", 32'(bus.IN), 32'h0);
    tick();
    IORSTN = 1'b1;
    tick();

    // cell 0 always drives
    shift_word(32'h0000_0002);
    chk("shift_no_disturb", 32'(PIN), 32'h0);
    load();
    ext_en = 8'hFE;
    #1;
    chk("c0_drv1_pin", 32'(PIN), 32'h01);
    chk("c0_drv1_in", 32'(bus.IN), 32'h01);
    bus.OUT = 8'hFE;
    #1;
    chk("c0_drv0_pin", 32'(PIN), 32'h00);
    bus.OUT = 8'hFF;

    // cell 3 under TS control, combinational
    bus.OUT = 8'hFE;
    shift_word(32'h0000_1000);
    bus.TS = 8'h08;
    bus.OUT = 8'hFF;
    load();
    ext_en = 8'hF7;
    #1;
    chk("c3_ts1_pin", 32'(PIN), 32'h08);
    chk("c3_ts1_in", 32'(bus.IN), 32'h08);
    bus.TS = 8'h00;
    ext_en = 8'hFF;
    #2;
    chk("c3_ts0_pin", 32'(PIN), 32'h00);
    ext_en = 8'hF7;
    bus.TS = 8'h08;
    #2;
    chk("c3_ts1b_pin", 32'(PIN), 32'h08);

    // cell 5 registered out and in
    bus.OUT = 8'h00;
    tick();
    tick();
    shift_word(32'h00E0_0000);
    load();
    ext_en = 8'hDF;
    #1;
    chk("c5_pre_pin", 32'(PIN), 32'h00);
    chk("c5_pre_in", 32'(bus.IN), 32'h00);
    bus.OUT = 8'h20;
    tick();
    chk("c5_k_pin", 32'(PIN), 32'h20);
    chk("c5_k_in", 32'(bus.IN), 32'h00);
    tick();
`ifdef IOBLOCK_BANK_SYNC2_EN
    chk("c5_k1_in", 32'(bus.IN), 32'h00);
`else
    chk("c5_k1_in", 32'(bus.IN), 32'h20);
`endif
    tick();
    chk("c5_k2_in", 32'(bus.IN), 32'h20);

    // chain flush, CFGLD ignored while shifting
    pat = 32'hA5C3_0F96;
    shift_word(pat);
    chk("flush_b31", 32'(bus.CFGOUT), 32'(pat[31]));
    bus.CFGEN = 1'b1;
    bus.CFGLD = 1'b1;
    bus.CFGIN = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      tick();
      expb = (k < 32) ? pat[31-k] : 1'b0;
      chk($sformatf("flush_%0d", k), 32'(bus.CFGOUT), 32'(expb));
    end
    bus.CFGEN = 1'b0;
    bus.CFGLD = 1'b0;
    #1;
    chk("ld_ignored_pin", 32'(PIN), 32'h20);
    chk("ld_ignored_in", 32'(bus.IN), 32'h20);

    // reset in the middle of a shift
    bus.OUT = 8'hFF;
    bus.CFGEN = 1'b1;
    bus.CFGIN = 1'b1;
    repeat (10) tick();
    IORSTN = 1'b0;
    bus.CFGEN = 1'b0;
    bus.CFGIN = 1'b0;
    #1;
    ext_en = 8'hFF;
    #1;
    chk("mid_rst_pin", 32'(PIN), 32'h00);
    chk("mid_rst_in", 32'(bus.IN), 32'h00);
    chk("mid_rst_cfgout", 32'(bus.CFGOUT), 32'h0);
    tick();
    IORSTN = 1'b1;
    tick();
    load();
    #1;
    chk("chain_cleared", 32'(PIN), 32'h00);
    shift_word(32'h0000_0022);
    load();
    ext_en = 8'hFC;
    #1;
    chk("reload_pin", 32'(PIN), 32'h03);
    chk("reload_in", 32'(bus.IN), 32'h03);
    chk("reload_cfgout", 32'(bus.CFGOUT), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
